rtc_bus_sequencer: RTL and testbench

// Sequences every access to the external RTC's multiplexed address/data bus.

---
 rtl/rtc_bus_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed-bus sequencer: arbitrates a read port and a write port and
// runs one timed ADDR/GAP/DATA/DONE/REC transaction per grant.
module rtc_bus_sequencer #(
   parameter int T_ADDR = 4,
   parameter int T_GAP  = 2,
   parameter int T_DATA = 11,
   parameter int T_REC  = 3
) (
   input  logic       clkC,
   input  logic       resetC_n,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   input  logic       rd_req,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       rd_ack,
   output logic       busy,
   output logic       bus_cs_n,
   output logic       bus_ale,
   output logic       bus_rd_n,
   output logic       bus_wr_n,
   output logic [7:0] bus_dout,
   output logic       bus_oe,
   input  logic [7:0] bus_din
);

   typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, DONE, REC} stateT;

   typedef struct packed {
      logic       isWrite;
      logic [7:0] addr;
      logic [7:0] data;
   } xferT;

   localparam logic [4:0] LD_ADDR = 5'(T_ADDR - 1);
   localparam logic [4:0] LD_GAP  = 5'(T_GAP - 1);
   localparam logic [4:0] LD_DATA = 5'(T_DATA - 1);
   localparam logic [4:0] LD_REC  = 5'(T_REC - 1);

   stateT      state, stateNext;
   logic [4:0] phaseCnt, phaseCntNext;
   xferT       xfer, xferNext;
   logic       lastGrantWr, lastGrantWrNext;
   logic       grantWr;

   // Bus pin values for the upcoming cycle, registered below so pins never glitch.
   logic       csNNext, aleNext, rdNNext, wrNNext, oeNext, busyNext;
   logic       wrAckNext, rdAckNext;
   logic [7:0] doutNext;

   // State, phase counter, latched transaction and round-robin history.
   always_ff @(posedge clkC or negedge resetC_n) begin
      if (!resetC_n) begin
         state       <= IDLE;
         phaseCnt    <= '0;
         xfer        <= '0;
         lastGrantWr <= 1'b0;
      end else begin
         state       <= stateNext;
         phaseCnt    <= phaseCntNext;
         xfer        <= xferNext;
         lastGrantWr <= lastGrantWrNext;
      end
   end

   // Next-state: grant only from IDLE, otherwise walk the timed phases.
   always_comb begin
      stateNext       = state;
      phaseCntNext    = phaseCnt;
      xferNext        = xfer;
      lastGrantWrNext = lastGrantWr;
      grantWr         = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req || rd_req) begin
               // On a tie, go opposite to the previous grant.
               grantWr          = wr_req && (!rd_req || !lastGrantWr);
               xferNext.isWrite = grantWr;
               xferNext.addr    = grantWr ? wr_addr : rd_addr;
               xferNext.data    = wr_data;
               lastGrantWrNext  = grantWr;
               stateNext        = ADDR;
               phaseCntNext     = LD_ADDR;
            end
         end
         ADDR: begin
            if (phaseCnt == 5'd0) begin
               stateNext    = GAP;
               phaseCntNext = LD_GAP;
            end else phaseCntNext = phaseCnt - 5'd1;
         end
         GAP: begin
            if (phaseCnt == 5'd0) begin
               stateNext    = DATA;
               phaseCntNext = LD_DATA;
            end else phaseCntNext = phaseCnt - 5'd1;
         end
         DATA: begin
            if (phaseCnt == 5'd0) begin
               stateNext    = DONE;
               phaseCntNext = 5'd0;
            end else phaseCntNext = phaseCnt - 5'd1;
         end
         DONE: begin
            stateNext    = REC;
            phaseCntNext = LD_REC;
         end
         REC: begin
            if (phaseCnt == 5'd0) begin
               stateNext    = IDLE;
               phaseCntNext = 5'd0;
            end else phaseCntNext = phaseCnt - 5'd1;
         end
         default: begin
            stateNext    = IDLE;
            phaseCntNext = 5'd0;
         end
      endcase
   end

   // Pin values decoded from the next state, so they line up with the phase.
   always_comb begin
      csNNext   = 1'b1;
      aleNext   = 1'b0;
      rdNNext   = 1'b1;
      wrNNext   = 1'b1;
      oeNext    = 1'b0;
      doutNext  = 8'h00;
      wrAckNext = 1'b0;
      rdAckNext = 1'b0;
      busyNext  = (stateNext != IDLE);
      case (stateNext)
         ADDR: begin
            csNNext  = 1'b0;
            aleNext  = 1'b1;
            oeNext   = 1'b1;
            doutNext = xferNext.addr;
         end
         GAP: csNNext = 1'b0;
         DATA: begin
            csNNext = 1'b0;
            if (xferNext.isWrite) begin
               wrNNext  = 1'b0;
               oeNext   = 1'b1;
               doutNext = xferNext.data;
            end else rdNNext = 1'b0;
         end
         DONE: begin
            wrAckNext = xferNext.isWrite;
            rdAckNext = !xferNext.isWrite;
         end
         default: ;
      endcase
   end

   // Registered pins; read data captured at the edge closing the last DATA cycle.
   always_ff @(posedge clkC or negedge resetC_n) begin
      if (!resetC_n) begin
         bus_cs_n <= 1'b1;
         bus_ale  <= 1'b0;
         bus_rd_n <= 1'b1;
         bus_wr_n <= 1'b1;
         bus_oe   <= 1'b0;
         bus_dout <= 8'h00;
         wr_ack   <= 1'b0;
         rd_ack   <= 1'b0;
         busy     <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         bus_cs_n <= csNNext;
         bus_ale  <= aleNext;
         bus_rd_n <= rdNNext;
         bus_wr_n <= wrNNext;
         bus_oe   <= oeNext;
         bus_dout <= doutNext;
         wr_ack   <= wrAckNext;
         rd_ack   <= rdAckNext;
         busy     <= busyNext;
         if (state == DATA && phaseCnt == 5'd0 && !xfer.isWrite) rd_data <= bus_din;
      end
   end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: cycle tables for single write/read,
// plus arbitration, period, mid-transaction reset and minimum-timing cases.
module tb_rtc_bus_sequencer;

   typedef struct {
      int          cyc;
      logic [15:0] exp;
      logic [15:0] mask;
   } vecT;

   localparam logic [15:0] MALL   = 16'hFFFF;
   localparam logic [15:0] MNOD   = 16'hFF00;
   localparam logic [15:0] MNODCS = 16'hEF00;

   logic clk, resetC_n;
   logic wrReq, rdReq, wrAck, rdAck, busy, csN, ale, rdN, wrN, oe;
   logic [7:0] wrAddr, wrData, rdAddr, rdData, dout, din;
   logic wrReqF, rdReqF, wrAckF, rdAckF, busyF, csNF, aleF, rdNF, wrNF, oeF;
   logic [7:0] rdDataF, doutF, dinF;

   int vecs = 0;
   int fails = 0;

   rtc_bus_sequencer dut (
      .clkC(clk), .resetC_n(resetC_n),
      .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData), .wr_ack(wrAck),
      .rd_req(rdReq), .rd_addr(rdAddr), .rd_data(rdData), .rd_ack(rdAck),
      .busy(busy), .bus_cs_n(csN), .bus_ale(ale), .bus_rd_n(rdN), .bus_wr_n(wrN),
      .bus_dout(dout), .bus_oe(oe), .bus_din(din));

   rtc_bus_sequencer #(.T_ADDR(1), .T_GAP(1), .T_DATA(1), .T_REC(1)) dutFast (
      .clkC(clk), .resetC_n(resetC_n),
      .wr_req(wrReqF), .wr_addr(8'h11), .wr_data(8'h22), .wr_ack(wrAckF),
      .rd_req(rdReqF), .rd_addr(8'h33), .rd_data(rdDataF), .rd_ack(rdAckF),
      .busy(busyF), .bus_cs_n(csNF), .bus_ale(aleF), .bus_rd_n(rdNF), .bus_wr_n(wrNF),
      .bus_dout(doutF), .bus_oe(oeF), .bus_din(dinF));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] pk(input logic b, wa, ra, cs, al, rd, wr, o,
                                      input logic [7:0] d);
      return {b, wa, ra, cs, al, rd, wr, o, d};
   endfunction

   function automatic logic [15:0] obs();
      return {busy, wrAck, rdAck, csN, ale, rdN, wrN, oe, dout};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, exp, mask);
      vecs++;
      if ((act & mask) !== (exp & mask)) begin
         fails++;
         $display("FAIL %s: got %h want %h (mask %h)", name, act, exp, mask);
      end
   endtask

   task automatic chkv(input string name, input int act, exp);
      vecs++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Advance to the middle of the next cycle; check strobe exclusivity on both DUTs.
   task automatic tick();
      @(negedge clk);
      vecs++;
      if ((oe && !rdN) || (!rdN && !wrN) || (oeF && !rdNF) || (!rdNF && !wrNF)) begin
         fails++;
         $display("FAIL strobeExcl: oe=%b rdN=%b wrN=%b oeF=%b rdNF=%b wrNF=%b",
                  oe, rdN, wrN, oeF, rdNF, wrNF);
      end
   endtask

   // Wait up to budget cycles for an ack; cyc=-1 if none.
   task automatic waitAck(input int budget, output int cyc, output logic isWr);
      cyc  = -1;
      isWr = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (wrAck || rdAck) begin
            cyc  = c;
            isWr = wrAck;
            break;
         end
      end
   endtask

   // Run cycles 1..22 after a grant edge, checking the table rows as they come up.
   task automatic runSeq(input string tag, input bit isWr, input vecT tbl[$],
                         input logic [7:0] prevRd);
      int ti = 0;
      for (int c = 1; c <= 22; c++) begin
         tick();
         while (ti < tbl.size() && tbl[ti].cyc == c) begin
            chk($sformatf("%s@%0d", tag, c), obs(), tbl[ti].exp, tbl[ti].mask);
            ti++;
         end
         if (!isWr && c == 17) chkv("rdDataBeforeCapture", int'(rdData), int'(prevRd));
         if (!isWr && c == 18) chkv("rdDataAtAck", int'(rdData), int'(din));
         if (wrAck) wrReq = 1'b0;
         if (rdAck) rdReq = 1'b0;
      end
   endtask

   initial begin
      vecT  wq[$];
      vecT  rq[$];
      int   c1, c2, c3;
      logic w1, w2, w3;
      logic sawAck;

      resetC_n = 1'b0;
      wrReq = 0; rdReq = 0; wrAddr = 0; wrData = 0; rdAddr = 0; din = 0;
      wrReqF = 0; rdReqF = 0; dinF = 0;

      // Write table: addr 0x21, data 0x35
      wq.push_back('{1,  pk(1,0,0,0,1,1,1,1,8'h21), MALL});
      wq.push_back('{4,  pk(1,0,0,0,1,1,1,1,8'h21), MALL});
      wq.push_back('{5,  pk(1,0,0,0,0,1,1,0,8'h00), MNOD});
      wq.push_back('{6,  pk(1,0,0,0,0,1,1,0,8'h00), MNOD});
      wq.push_back('{7,  pk(1,0,0,0,0,1,0,1,8'h35), MALL});
      wq.push_back('{17, pk(1,0,0,0,0,1,0,1,8'h35), MALL});
      wq.push_back('{18, pk(1,1,0,1,0,1,1,0,8'h00), MNODCS});
      wq.push_back('{19, pk(1,0,0,1,0,1,1,0,8'h00), MNOD});
      wq.push_back('{21, pk(1,0,0,1,0,1,1,0,8'h00), MNOD});
      wq.push_back('{22, pk(0,0,0,1,0,1,1,0,8'h00), MNOD});
      // Read table: addr 0x24
      rq.push_back('{1,  pk(1,0,0,0,1,1,1,1,8'h24), MALL});
      rq.push_back('{4,  pk(1,0,0,0,1,1,1,1,8'h24), MALL});
      rq.push_back('{5,  pk(1,0,0,0,0,1,1,0,8'h00), MNOD});
      rq.push_back('{7,  pk(1,0,0,0,0,0,1,0,8'h00), MNOD});
      rq.push_back('{17, pk(1,0,0,0,0,0,1,0,8'h00), MNOD});
      rq.push_back('{18, pk(1,0,1,1,0,1,1,0,8'h00), MNODCS});
      rq.push_back('{21, pk(1,0,0,1,0,1,1,0,8'h00), MNOD});
      rq.push_back('{22, pk(0,0,0,1,0,1,1,0,8'h00), MNOD});

      tick(); tick();
      chk("resetState", obs(), pk(0,0,0,1,0,1,1,0,8'h00), MALL);
      chkv("resetRdData", int'(rdData), 0);
      resetC_n = 1'b1;
      tick(); tick();
      chk("idleAfterReset", obs(), pk(0,0,0,1,0,1,1,0,8'h00), MALL);

      // Single write
      wrAddr = 8'h21; wrData = 8'h35; wrReq = 1'b1;
      runSeq("wr", 1'b1, wq, 8'h00);

      // Single read; rd_data must hold after the read
      rdAddr = 8'h24; din = 8'h59; rdReq = 1'b1;
      runSeq("rd", 1'b0, rq, 8'h00);
      din = 8'hAA;
      repeat (5) tick();
      chkv("rdDataHeld", int'(rdData), 8'h59);

      // Unopposed reads back to back
      rdReq = 1'b1;
      waitAck(40, c1, w1);
      waitAck(40, c2, w2);
      rdReq = 1'b0;
      chkv("rdOnlyLatency", c1, 18);
      chkv("rdOnlyPeriod", c2, 22);
      chkv("rdOnlyIsRead", int'(w2), 0);
      repeat (6) tick();

      // Ties after reset: write, read, write
      resetC_n = 1'b0;
      tick();
      resetC_n = 1'b1;
      tick();
      wrAddr = 8'h40; wrData = 8'h41; rdAddr = 8'h42; din = 8'h77;
      wrReq = 1'b1; rdReq = 1'b1;
      waitAck(40, c1, w1);
      waitAck(40, c2, w2);
      chkv("tieRdData", int'(rdData), 8'h77);
      waitAck(40, c3, w3);
      wrReq = 1'b0; rdReq = 1'b0;
      chkv("tie1Cycle", c1, 18);
      chkv("tie1Write", int'(w1), 1);
      chkv("tie2Cycle", c2, 22);
      chkv("tie2Read", int'(w2), 0);
      chkv("tie3Cycle", c3, 22);
      chkv("tie3Write", int'(w3), 1);
      repeat (6) tick();

      // Reset during DATA of a write
      wrAddr = 8'h50; wrData = 8'h66; wrReq = 1'b1;
      repeat (10) tick();
      chk("preAbortData", obs(), pk(1,0,0,0,0,1,0,1,8'h66), MALL);
      #2 resetC_n = 1'b0;
      #1 chk("abortImmediate", obs(), pk(0,0,0,1,0,1,1,0,8'h00), MALL);
      wrReq = 1'b0;
      tick();
      resetC_n = 1'b1;
      sawAck = 1'b0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (wrAck || rdAck || busy) sawAck = 1'b1;
      end
      chkv("noActivityAfterAbort", int'(sawAck), 0);
      wrReq = 1'b1;
      waitAck(40, c1, w1);
      wrReq = 1'b0;
      chkv("reissueLatency", c1, 18);
      chkv("reissueWrite", int'(w1), 1);
      repeat (6) tick();

      // Minimum timing on the fast instance: tie -> write, then read
      dinF = 8'h3C; wrReqF = 1'b1; rdReqF = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 4) begin
            chkv("fastWrAck@4", int'(wrAckF), 1);
            chkv("fastRdAckNot@4", int'(rdAckF), 0);
         end
         if (c == 5) chkv("fastBusyRec@5", int'(busyF), 1);
         if (c == 6) chkv("fastIdle@6", int'(busyF), 0);
         if (c == 7) chkv("fastNextGrantAle@7", int'(aleF), 1);
         if (c == 10) begin
            chkv("fastRdAck@10", int'(rdAckF), 1);
            chkv("fastRdData@10", int'(rdDataF), 8'h3C);
         end
         if (wrAckF) wrReqF = 1'b0;
         if (rdAckF) rdReqF = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
